// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus stability-counter FSM for a mechanical push-button.
// Optional long-press detector is built only when DEBOUNCE_LONG_PRESS_EN is defined.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int LONG_PRESS_CYCLES = 50000000,
    parameter int CNT_WIDTH         = 26,
    parameter bit BTN_ACTIVE_LOW    = 1'b0,
    parameter bit RESET_DIR         = 1'b1
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic up_down,
    output logic long_press
);

    typedef enum logic [1:0] {
        S_LOW,
        S_WAIT_HIGH,
        S_HIGH,
        S_WAIT_LOW
    } state_t;

    localparam int CNT_SAT_INT = (DEBOUNCE_CYCLES > LONG_PRESS_CYCLES) ?
                                 DEBOUNCE_CYCLES : LONG_PRESS_CYCLES;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_SAT  = CNT_WIDTH'(CNT_SAT_INT);
    localparam logic [CNT_WIDTH-1:0] DEB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] LONG_DONE = CNT_WIDTH'(LONG_PRESS_CYCLES);
`endif

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic                 s0_q, s0_d;
    logic                 s1_q, s1_d;
    logic                 level_q, level_d;
    logic                 press_q, press_d;
    logic                 release_q, release_d;
    logic                 up_down_q, up_down_d;
`ifdef DEBOUNCE_LONG_PRESS_EN
    logic                 long_q, long_d;
`endif

    always_comb begin
        s0_d      = btn_raw ^ BTN_ACTIVE_LOW;
        s1_d      = s0_q;
        cnt_inc   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        up_down_d = up_down_q;
`ifdef DEBOUNCE_LONG_PRESS_EN
        long_d    = 1'b0;
`endif

        unique case (state_q)
            S_LOW: begin
                if (s1_q) begin
                    state_d = S_WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            S_WAIT_HIGH: begin
                if (!s1_q) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d   = S_HIGH;
                    cnt_d     = '0;
                    press_d   = 1'b1;
                    up_down_d = ~up_down_q;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_HIGH: begin
                if (!s1_q) begin
                    state_d = S_WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end else begin
`ifdef DEBOUNCE_LONG_PRESS_EN
                    // Parking the count one past the trigger value yields a single pulse per hold.
                    if (cnt_q == LONG_LAST) begin
                        long_d = 1'b1;
                        cnt_d  = LONG_DONE;
                    end else if (cnt_q < LONG_LAST) begin
                        cnt_d = cnt_inc;
                    end
`else
                    cnt_d = '0;
`endif
                end
            end
            S_WAIT_LOW: begin
                if (s1_q) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d   = S_LOW;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
            end
        endcase

        level_d = (state_d == S_HIGH) || (state_d == S_WAIT_LOW);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            s0_q      <= 1'b0;
            s1_q      <= 1'b0;
            state_q   <= S_LOW;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            up_down_q <= RESET_DIR;
`ifdef DEBOUNCE_LONG_PRESS_EN
            long_q    <= 1'b0;
`endif
        end else begin
            s0_q      <= s0_d;
            s1_q      <= s1_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            up_down_q <= up_down_d;
`ifdef DEBOUNCE_LONG_PRESS_EN
            long_q    <= long_d;
`endif
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign up_down     = up_down_q;
`ifdef DEBOUNCE_LONG_PRESS_EN
    assign long_press  = long_q;
`else
    assign long_press  = 1'b0;
`endif

endmodule
